uart_tx_baud: RTL
=================

# uart_tx_baud

Serial transmitter that sits directly downstream of the clock divider. It takes the divider's output as a 1x baud clock and shifts out parallel words as asynchronous serial frames on `tx_o`. Per frame: start bit, data LSB-first, optional parity, 1 or 2 stop bits. Used for the Uniboard's debug and telemetry UART lines.

## Interface
Parameters:
- `DATA_BITS`, default 8: data bits per frame; legal range 5–9.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: 1 or 2.

Ports:
- `clk_i`, input, 1: system clock; the same clock that drives the divider.
- `reset`, input, 1: asynchronous, active-high reset.
- `baud_clk_i`, input, 1: divider output, synchronous to `clk_i`. Each rising edge marks one bit-period boundary.
- `data_i`, input, DATA_BITS: word to send; sampled on accept.
- `valid_i`, input, 1: word available.
- `ready_o`, output, 1: high only in IDLE. A word is accepted on any `clk_i` edge with `valid_i & ready_o`.
- `tx_o`, output, 1: serial line, idle high, registered.
- `busy_o`, output, 1: high whenever state is not IDLE.

## Operation
- Tick detection:
  - `baud_q` registers `baud_clk_i`.
  - `tick = baud_clk_i & ~baud_q` (one `clk_i` cycle per rising edge).
  - No synchronizer, because both signals are in the same clock domain.
- States: IDLE, ARMED, START, DATA, PARITY, STOP.
  - IDLE: `tx_o`=1. On accept, latch `data_i` into the shift register and compute the parity bit, then go to ARMED.
  - ARMED: `tx_o`=1. On tick, go to START. A tick in the same cycle as the accept does not count; ARMED waits for the next tick.
  - START: `tx_o`=0. On tick, go to DATA with bit index 0.
  - DATA: `tx_o` = shift-register bit 0. On each tick:
    - shift right and increment the index;
    - after the tick that ends bit DATA_BITS-1, go to PARITY if `PARITY`≠0, otherwise go to STOP.
  - PARITY: `tx_o` = parity bit. On tick, go to STOP.
  - STOP: `tx_o`=1. Count STOP_BITS ticks, then go to IDLE.
- Parity is computed over the latched word: odd = `~^data`, even = `^data`.
- `valid_i` while not in IDLE is ignored and the word is not latched. The upstream source must hold `valid_i` until accepted.
- Outputs while reset is asserted, and immediately after it is applied:

  | Signal | Value |
  |---|---|
  | state | IDLE |
  | `tx_o` | 1 |
  | `ready_o` | 1 |
  | `busy_o` | 0 |
  | `baud_q` | 0 |
  | shift register, counters | 0 |

  `valid_i` is ignored while `reset` is high.
- Reset mid-frame abandons the frame: `tx_o` returns high asynchronously and no partial retransmission occurs.
- Parameter values outside the legal ranges are a synthesis-time error (generate an `$error`).

## Timing
- All state changes and `tx_o` updates occur on the `clk_i` edge that ends a tick cycle. Each bit therefore lasts exactly one `baud_clk_i` period, which is `factor` `clk_i` cycles.
- `ready_o` and `busy_o` are combinational from state:
  - `ready_o` falls in the cycle after accept.
  - `ready_o` rises in the cycle after the tick that ends the last stop bit.
- Accept-to-start latency: from the accept edge to the first following tick, plus 1 cycle. Worst case is `factor`+1 cycles.
- Frame length: 1 + DATA_BITS + (PARITY≠0) + STOP_BITS bit periods.
- Back-to-back words: if the next word is presented the cycle `ready_o` rises, the line sees at least one extra idle-high bit period (the ARMED wait) between frames. This is intentional.
- If `baud_clk_i` is held constant, no ticks occur. The block stays in its current state indefinitely with `tx_o` stable.
- Minimum legal divider factor is 2; factor 1 produces no edges.

## Test plan
1. **8N1 frame.** Stimulus: DATA_BITS=8, PARITY=0, STOP_BITS=1; `baud_clk_i` pattern 0,0,1,1 repeating (factor 4); send 0xA5. Required: `tx_o` bit sequence 0,1,0,1,0,0,1,0,1,1, each bit held exactly 4 cycles; `ready_o` low for the whole frame and high again after the stop bit.
2. **Parity.** Stimulus: even parity, send 0x07, then odd parity, send 0x07. Required: parity bit is 1 for even, 0 for odd. Also send 0x00 with even parity; required parity bit 0.
3. **Busy and stalled baud.**
   - Stimulus: pulse `valid_i` with 0x3C while the block is busy. Required: the word is ignored and the frame in progress is unchanged.
   - Stimulus: hold `baud_clk_i` low after an accept. Required: state stays ARMED, `tx_o`=1, `busy_o`=1.
4. **Back-to-back and tick collision.** Stimulus: `valid_i` held high with 0x55 then 0xAA, STOP_BITS=2. Required:
   - two correct frames;
   - exactly 2 stop periods, then 1 idle period, between the frames;
   - an accept coinciding with a tick delays START to the next tick.
5. **Reset mid-frame.** Stimulus: assert `reset` during DATA bit 3. Required:
   - `tx_o`=1, `ready_o`=1, `busy_o`=0 immediately, without waiting for a clock edge;
   - after release, a new word 0x81 transmits correctly.
6. **Width corners.** Stimulus: DATA_BITS=5 and DATA_BITS=9. Required: send 0x1F and 0x1FF; frames are 7 and 11 bit periods long (8N1 equivalent framing, one stop bit), with the correct bit order.

Source files
------------

// File: rtl/uart_tx_baud.sv
// UART transmitter clocked by a 1x baud strobe from the clock divider.
// Frame: start bit, DATA_BITS data bits LSB-first, optional parity, STOP_BITS stop bits.
module uart_tx_baud #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk_i,
    input  logic                 reset,
    input  logic                 baud_clk_i,
    input  logic [DATA_BITS-1:0] data_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic                 tx_o,
    output logic                 busy_o
);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_baud: DATA_BITS must be in 5..9");
    end
    if (PARITY > 2) begin : g_bad_parity
        $error("uart_tx_baud: PARITY must be 0 (none), 1 (odd) or 2 (even)");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_baud: STOP_BITS must be 1 or 2");
    end

    localparam logic [3:0] LAST_IDX   = 4'(DATA_BITS - 1);
    localparam logic       LAST_STOP  = 1'(STOP_BITS - 1);
    localparam bit         HAS_PARITY = (PARITY != 0);
    localparam bit         ODD_PARITY = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state;
    logic                 baud_q;
    logic                 tick;
    logic                 parity_bit;
    logic                 stop_cnt;
    logic [3:0]           bit_idx;
    logic [DATA_BITS-1:0] shift;

    // Same clock domain as the divider, so a plain edge detect is enough.
    always_comb begin
        tick = baud_clk_i & ~baud_q;
    end

    always_comb begin
        ready_o = (state == S_IDLE);
        busy_o  = (state != S_IDLE);
    end

    // tx_o is updated together with the state so each bit starts on the edge ending a tick cycle.
    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            tx_o       <= 1'b1;
            baud_q     <= 1'b0;
            shift      <= '0;
            bit_idx    <= '0;
            stop_cnt   <= 1'b0;
            parity_bit <= 1'b0;
        end else begin
            baud_q <= baud_clk_i;
            case (state)
                S_IDLE: begin
                    tx_o <= 1'b1;
                    if (valid_i) begin
                        shift      <= data_i;
                        parity_bit <= ODD_PARITY ? ~^data_i : ^data_i;
                        state      <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (tick) begin
                        tx_o  <= 1'b0;
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (tick) begin
                        tx_o    <= shift[0];
                        bit_idx <= '0;
                        state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        if (bit_idx == LAST_IDX) begin
                            if (HAS_PARITY) begin
                                tx_o  <= parity_bit;
                                state <= S_PARITY;
                            end else begin
                                tx_o     <= 1'b1;
                                stop_cnt <= 1'b0;
                                state    <= S_STOP;
                            end
                        end else begin
                            shift   <= {1'b0, shift[DATA_BITS-1:1]};
                            tx_o    <= shift[1];
                            bit_idx <= bit_idx + 4'd1;
                        end
                    end
                end
                S_PARITY: begin
                    if (tick) begin
                        tx_o     <= 1'b1;
                        stop_cnt <= 1'b0;
                        state    <= S_STOP;
                    end
                end
                S_STOP: begin
                    tx_o <= 1'b1;
                    if (tick) begin
                        if (stop_cnt == LAST_STOP) begin
                            state <= S_IDLE;
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    tx_o  <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
